// File: rtl/top_of_tops_pkg.sv
// Shared definitions for the top_of_tops debug harness: FSM encodings,
// command bytes, the halt word and byte-select helpers for the TX path.
package top_of_tops_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_RUN     = 4'd2,
    ST_STEP    = 4'd3,
    ST_REPORT  = 4'd4,
    ST_DUMP    = 4'd5,
    ST_WAIT_TX = 4'd6
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'd1;
  localparam logic [7:0] CMD_RUN  = 8'd2;
  localparam logic [7:0] CMD_STEP = 8'd7;
  localparam logic [7:0] CMD_DUMP = 8'd8;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int REPORT_BYTES = 8;

  // Byte k of a word, k = 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    return 8'(w >> {~k, 3'b000});
  endfunction

  // Byte k of the {pc, cycle_count} report, k = 0 being PC[31:24].
  function automatic logic [7:0] report_byte(input logic [31:0] pc, input logic [31:0] cnt,
                                             input logic [2:0] k);
    return 8'({pc, cnt} >> {~k, 3'b000});
  endfunction

endpackage

// File: rtl/top_of_tops_instr_mem.sv
// Instruction memory: byte-wide synchronous writes, word-wide asynchronous read.
// Byte address 4w+0 lands in bits DWORD-1 -: 8 of word w (big-endian).
module instr_mem #(
  parameter int ADDR  = 7,
  parameter int DWORD = 32
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ADDR:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [ADDR-2:0]  rd_addr,
  output logic [DWORD-1:0] rd_data
);

  localparam int LANES = DWORD / 8;
  localparam int WORDS = 2 ** (ADDR - 1);

  // One byte-wide array per lane keeps each write a plain single-lane store.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];

      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr[1:0] == 2'(gi))) begin
          lane_mem[wr_addr[ADDR:2]] <= wr_data;
        end
      end

      assign rd_data[DWORD-1-8*gi -: 8] = lane_mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/top_of_tops.sv
// top_of_tops: UART-driven debug harness that loads, runs, steps, reports and dumps
// the instruction memory. Define DBG_STEP_EN to build the single-step command (7).
import top_of_tops_pkg::*;

module top_of_tops #(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int ADDR    = 7,
  parameter int RB_ADDR = 5
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_clock_reset,
  input  logic            i_rx_done,
  input  logic [BYTE-1:0] i_rx_data,
  input  logic            i_tx_done,
  output logic [3:0]      o_state,
  output logic [BYTE-1:0] o_tx_data,
  output logic            o_tx_start
);

  localparam int TX_IDX_W = RB_ADDR + 2;
  localparam logic [TX_IDX_W-1:0] REPORT_LAST = TX_IDX_W'(REPORT_BYTES - 1);
  localparam logic [TX_IDX_W-1:0] DUMP_LAST   = '1;

  logic                srst;
  state_t              state_reg, state_next;
  logic                rx_prev_reg;
  logic                rx_event;
  logic [ADDR:0]       byte_cnt_reg;
  logic [DWORD-1:0]    pc_reg;
  logic [DWORD-1:0]    cycle_cnt_reg;
  logic [ADDR:0]       pc_low_next;
  logic [TX_IDX_W-1:0] tx_idx_reg;
  logic                tx_dump_reg;
  logic                tx_last;
  logic [BYTE-1:0]     tx_data_reg, tx_data_next;
  logic                tx_start_reg, tx_start_next;
  logic                mem_wr_en;
  logic [ADDR-2:0]     rd_addr;
  logic [DWORD-1:0]    instr;
  logic                fetch_en;
  logic                is_halt;
  logic                last_fetch;

  // An unlocked clock generator holds the block exactly as reset does.
  assign srst     = ~i_reset | i_clock_reset;
  assign rx_event = i_rx_done & ~rx_prev_reg;

  assign is_halt     = (instr == HALT_WORD);
  assign last_fetch  = (pc_reg[ADDR:2] == '1);
  assign pc_low_next = pc_reg[ADDR:0] + (ADDR+1)'(4);
  assign tx_last     = tx_dump_reg ? (tx_idx_reg == DUMP_LAST) : (tx_idx_reg == REPORT_LAST);

`ifdef DBG_STEP_EN
  assign fetch_en = (state_reg == ST_RUN) || (state_reg == ST_STEP);
`else
  assign fetch_en = (state_reg == ST_RUN);
`endif

  // The single read port serves the dump walk in DUMP and the fetch engine otherwise.
  assign rd_addr = (state_reg == ST_DUMP) ? (ADDR-1)'(tx_idx_reg[TX_IDX_W-1:2])
                                          : pc_reg[ADDR:2];

  instr_mem #(
    .ADDR  (ADDR),
    .DWORD (DWORD)
  ) u_instr_mem (
    .clk     (i_clock),
    .wr_en   (mem_wr_en),
    .wr_addr (byte_cnt_reg),
    .wr_data (i_rx_data),
    .rd_addr (rd_addr),
    .rd_data (instr)
  );

  always_ff @(posedge i_clock) begin
    if (srst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rx_event) begin
          case (i_rx_data)
            CMD_LOAD: state_next = ST_LOAD;
            CMD_RUN:  state_next = ST_RUN;
`ifdef DBG_STEP_EN
            CMD_STEP: state_next = ST_STEP;
`else
            CMD_STEP: state_next = ST_IDLE;
`endif
            CMD_DUMP: state_next = ST_DUMP;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        if (rx_event && (byte_cnt_reg == '1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (is_halt || last_fetch) begin
          state_next = ST_REPORT;
        end
      end
`ifdef DBG_STEP_EN
      ST_STEP:   state_next = ST_REPORT;
`endif
      ST_REPORT: state_next = ST_WAIT_TX;
      ST_DUMP:   state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (tx_last) begin
            state_next = ST_IDLE;
          end else begin
            state_next = tx_dump_reg ? ST_DUMP : ST_REPORT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    mem_wr_en     = 1'b0;
    case (state_reg)
      ST_LOAD: mem_wr_en = rx_event;
      ST_REPORT: begin
        tx_start_next = 1'b1;
        tx_data_next  = report_byte(pc_reg, cycle_cnt_reg, tx_idx_reg[2:0]);
      end
      ST_DUMP: begin
        tx_start_next = 1'b1;
        tx_data_next  = word_byte(instr, tx_idx_reg[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (srst) begin
      rx_prev_reg   <= 1'b0;
      byte_cnt_reg  <= '0;
      pc_reg        <= '0;
      cycle_cnt_reg <= '0;
      tx_idx_reg    <= '0;
      tx_dump_reg   <= 1'b0;
      tx_data_reg   <= '0;
      tx_start_reg  <= 1'b0;
    end else begin
      rx_prev_reg  <= i_rx_done;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;

      if ((state_reg == ST_IDLE) && (state_next == ST_LOAD)) begin
        byte_cnt_reg <= '0;
      end else if (mem_wr_en) begin
        byte_cnt_reg <= byte_cnt_reg + (ADDR+1)'(1);
      end

      // A halt fetch leaves PC and the count untouched; PC wraps within the memory.
      if (fetch_en && !is_halt) begin
        pc_reg        <= DWORD'(pc_low_next);
        cycle_cnt_reg <= cycle_cnt_reg + DWORD'(1);
      end

      if ((state_reg != ST_WAIT_TX) &&
          ((state_next == ST_REPORT) || (state_next == ST_DUMP))) begin
        tx_idx_reg  <= '0;
        tx_dump_reg <= (state_next == ST_DUMP);
      end else if ((state_reg == ST_WAIT_TX) && i_tx_done) begin
        tx_idx_reg <= tx_idx_reg + TX_IDX_W'(1);
      end
    end
  end

  assign o_state    = state_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_tx_start = tx_start_reg;

endmodule

// File: tb/tb_top_of_tops.sv
// Directed bench for top_of_tops: reset, load, command decode table, run/report,
// abort, optional step, dump handshake and PC wrap.
module tb_top_of_tops;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clk_rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic [3:0] o_state;
  logic [7:0] o_tx_data;
  logic       o_tx_start;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_mem [256];
  logic [7:0] tx_q [$];

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] exp_state;
  } cmd_vec_t;

  cmd_vec_t vecs [8];

`ifdef DBG_STEP_EN
  localparam logic [3:0] STEP_STATE = 4'd3;
`else
  localparam logic [3:0] STEP_STATE = 4'd0;
`endif

  top_of_tops dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_clock_reset (clk_rst),
    .i_rx_done     (rx_done),
    .i_rx_data     (rx_data),
    .i_tx_done     (tx_done),
    .o_state       (o_state),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start)
  );

  always #5 clk = ~clk;

  // Capture every transmit request shortly after the edge that produced it.
  always @(posedge clk) begin
    #2;
    if (o_tx_start === 1'b1) tx_q.push_back(o_tx_data);
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Two-cycle rx_done pulse; returns o_state one cycle after the receive event.
  task automatic send_byte(input logic [7:0] b, output logic [3:0] st);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    st = o_state;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'(o_state), 64'd0);
    rst_n = 1'b1;
    tx_q.delete();
  endtask

  task automatic get_tx(input string name, input int hold, output logic [7:0] d);
    int t;
    int bad;
    t   = 0;
    bad = 0;
    d   = 8'h00;
    while (tx_q.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (tx_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_start no tx_start within 100 cycles actual=0 required=1", name);
      return;
    end
    d = tx_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (o_tx_data !== d) bad++;
    end
    if (hold > 0) begin
      chk({name, "_held"}, 64'(bad), 64'd0);
      chk({name, "_one_start"}, 64'(tx_q.size()), 64'd0);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic check_report(input string name, input logic [63:0] exp64);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) begin
      get_tx($sformatf("%s_b%0d", name, k), 0, d);
      chk($sformatf("%s_b%0d", name, k), 64'(d), 64'(8'(exp64 >> (56 - 8 * k))));
    end
    chk({name, "_idle"}, 64'(o_state), 64'd0);
    chk({name, "_no_extra"}, 64'(tx_q.size()), 64'd0);
  endtask

  task automatic load_mem(input string name);
    logic [3:0] st;
    send_byte(8'd1, st);
    chk({name, "_enter"}, 64'(st), 64'd1);
    for (int i = 0; i < 256; i++) begin
      send_byte(exp_mem[i], st);
      chk($sformatf("%s_state[%0d]", name, i), 64'(st), (i == 255) ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    logic [3:0] st;
    logic [7:0] d;
    int         starts;

    vecs[0] = '{8'd9,   4'd0};
    vecs[1] = '{8'd0,   4'd0};
    vecs[2] = '{8'd255, 4'd0};
    vecs[3] = '{8'd3,   4'd0};
    vecs[4] = '{8'd7,   STEP_STATE};
    vecs[5] = '{8'd2,   4'd2};
    vecs[6] = '{8'd8,   4'd5};
    vecs[7] = '{8'd1,   4'd1};

    // Program: words 0..2 = 1, word 3 = halt, remaining bytes a fixed pattern.
    for (int i = 0; i < 256; i++) begin
      if (i < 12)      exp_mem[i] = ((i % 4) == 3) ? 8'h01 : 8'h00;
      else if (i < 16) exp_mem[i] = 8'hFF;
      else             exp_mem[i] = 8'((i * 7 + 3) & 255);
    end

    repeat (3) @(negedge clk);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_tx_start", 64'(o_tx_start), 64'd0);
    chk("rst_tx_data", 64'(o_tx_data), 64'd0);

    rst_n = 1'b1;
    send_byte(8'd1, st);
    chk("clkrst_hold_state", 64'(st), 64'd0);
    clk_rst = 1'b0;
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_tx_start === 1'b1) starts++;
    end
    chk("idle_no_tx", 64'(starts), 64'd0);
    tx_q.delete();

    load_mem("load1");

    for (int i = 0; i < 8; i++) begin
      do_reset();
      send_byte(vecs[i].cmd, st);
      chk($sformatf("cmd_%0d_state", vecs[i].cmd), 64'(st), 64'(vecs[i].exp_state));
    end

    // Abort mid-RUN: state must return to IDLE on the next cycle.
    do_reset();
    send_byte(8'd2, st);
    chk("abort_running", 64'(o_state), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_state", 64'(o_state), 64'd0);
    chk("abort_tx_start", 64'(o_tx_start), 64'd0);
    rst_n = 1'b1;
    tx_q.delete();

    // RUN: 3 instructions + halt = 4 cycles, REPORT, then first start.
    send_byte(8'd2, st);
    chk("run_enter", 64'(st), 64'd2);
    @(negedge clk);
    chk("run_cycle4", 64'(o_state), 64'd2);
    @(negedge clk);
    chk("run_report", 64'(o_state), 64'd4);
    @(negedge clk);
    chk("run_first_start", 64'(o_tx_start), 64'd1);
    chk("run_wait_tx", 64'(o_state), 64'd6);
    check_report("run_rep", 64'h0000000C_00000003);

`ifdef DBG_STEP_EN
    do_reset();
    send_byte(8'd7, st);
    chk("step1_enter", 64'(st), 64'd3);
    check_report("step1_rep", 64'h00000004_00000001);
    send_byte(8'd7, st);
    check_report("step2_rep", 64'h00000008_00000002);
`endif

    // DUMP: tx_done in IDLE is ignored; first byte held while tx_done stays low.
    do_reset();
    tx_done = 1'b1;
    repeat (2) @(negedge clk);
    tx_done = 1'b0;
    chk("txdone_idle_state", 64'(o_state), 64'd0);
    send_byte(8'd8, st);
    chk("dump_enter", 64'(st), 64'd5);
    get_tx("dump_b0", 6, d);
    chk("dump_b0", 64'(d), 64'(exp_mem[0]));
    for (int k = 1; k < 128; k++) begin
      get_tx($sformatf("dump_b%0d", k), k % 3, d);
      chk($sformatf("dump_b%0d", k), 64'(d), 64'(exp_mem[k]));
    end
    chk("dump_idle", 64'(o_state), 64'd0);
    chk("dump_no_extra", 64'(tx_q.size()), 64'd0);

    // No halt anywhere: RUN stops after the word at 252, PC wraps to 0, count 64.
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i);
    do_reset();
    load_mem("load2");
    send_byte(8'd2, st);
    chk("wrap_enter", 64'(st), 64'd2);
    check_report("wrap_rep", 64'h00000000_00000040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
